// File: rtl/uart_tx_fifo.sv
// rtl/uart_tx_fifo.sv - buffered UART transmitter draining a FIFO as back-to-back serial frames
// Optional even-parity bit between data and stop bits: define UART_TX_PARITY_EN.
module uart_tx_fifo #(
  parameter int CLKS_PER_BIT = 868,
  parameter int DATA_BITS    = 8,
  parameter int STOP_BITS    = 1,
  parameter int FIFO_DEPTH   = 16,
  parameter int LVL_W        = $clog2(FIFO_DEPTH) + 1
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 wr_en,
  input  logic [DATA_BITS-1:0] wr_data,
  output logic                 full,
  output logic                 empty,
  output logic [LVL_W-1:0]     level,
  output logic                 busy,
  output logic                 overflow,
  output logic                 uart_tx
);

  localparam int PTR_W  = $clog2(FIFO_DEPTH);
  localparam int BAUD_W = $clog2(CLKS_PER_BIT);
  localparam int BIT_W  = $clog2(DATA_BITS);

`ifdef UART_TX_PARITY_EN
  typedef enum logic [2:0] {S_IDLE, S_START, S_DATA, S_PARITY, S_STOP} state_t;
`else
  typedef enum logic [2:0] {S_IDLE, S_START, S_DATA, S_STOP} state_t;
`endif

  state_t               state, state_nxt;
  logic [BAUD_W-1:0]    baud_cnt, baud_nxt;
  logic [BIT_W-1:0]     bit_cnt, bit_nxt;
  logic [DATA_BITS-1:0] shift_q, shift_nxt;
  logic [DATA_BITS-1:0] mem [FIFO_DEPTH];
  logic [PTR_W-1:0]     wr_ptr, rd_ptr;
  logic [LVL_W-1:0]     level_q;
  logic                 ovf_q;
  logic                 push, pop, baud_done;
`ifdef UART_TX_PARITY_EN
  logic                 parity_q;
`endif

  assign full     = (level_q == LVL_W'(FIFO_DEPTH));
  assign empty    = (level_q == '0);
  assign level    = level_q;
  assign overflow = ovf_q;
  assign busy     = (state != S_IDLE) | ~empty;
  assign push     = wr_en & ~full;
  assign baud_done = (baud_cnt == BAUD_W'(CLKS_PER_BIT - 1));

  always_comb begin
    state_nxt = state;
    baud_nxt  = baud_cnt + 1'b1;
    bit_nxt   = bit_cnt;
    shift_nxt = shift_q;
    pop       = 1'b0;
    uart_tx   = 1'b1;
    case (state)
      S_IDLE: begin
        baud_nxt = '0;
        bit_nxt  = '0;
        if (!empty) begin
          pop       = 1'b1;
          shift_nxt = mem[rd_ptr];
          state_nxt = S_START;
        end
      end
      S_START: begin
        uart_tx = 1'b0;
        if (baud_done) begin
          baud_nxt  = '0;
          bit_nxt   = '0;
          state_nxt = S_DATA;
        end
      end
      S_DATA: begin
        uart_tx = shift_q[0];
        if (baud_done) begin
          baud_nxt  = '0;
          shift_nxt = shift_q >> 1;
          if (bit_cnt == BIT_W'(DATA_BITS - 1)) begin
            bit_nxt = '0;
`ifdef UART_TX_PARITY_EN
            state_nxt = S_PARITY;
`else
            state_nxt = S_STOP;
`endif
          end else begin
            bit_nxt = bit_cnt + 1'b1;
          end
        end
      end
`ifdef UART_TX_PARITY_EN
      S_PARITY: begin
        uart_tx = parity_q;
        if (baud_done) begin
          baud_nxt  = '0;
          bit_nxt   = '0;
          state_nxt = S_STOP;
        end
      end
`endif
      S_STOP: begin
        if (baud_done) begin
          baud_nxt = '0;
          if (bit_cnt == BIT_W'(STOP_BITS - 1)) begin
            bit_nxt = '0;
            // Chain straight into the next start bit so queued frames leave no idle gap.
            if (!empty) begin
              pop       = 1'b1;
              shift_nxt = mem[rd_ptr];
              state_nxt = S_START;
            end else begin
              state_nxt = S_IDLE;
            end
          end else begin
            bit_nxt = bit_cnt + 1'b1;
          end
        end
      end
      default: state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state    <= S_IDLE;
      baud_cnt <= '0;
      bit_cnt  <= '0;
      shift_q  <= '0;
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      level_q  <= '0;
      ovf_q    <= 1'b0;
`ifdef UART_TX_PARITY_EN
      parity_q <= 1'b0;
`endif
    end else begin
      state    <= state_nxt;
      baud_cnt <= baud_nxt;
      bit_cnt  <= bit_nxt;
      shift_q  <= shift_nxt;
      ovf_q    <= wr_en & full;
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
      if (push && !pop)      level_q <= level_q + 1'b1;
      else if (pop && !push) level_q <= level_q - 1'b1;
`ifdef UART_TX_PARITY_EN
      if (pop) parity_q <= ^mem[rd_ptr];
`endif
    end
  end

  // Storage carries no reset; occupancy alone decides what is valid.
  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= wr_data;
  end

endmodule

// File: tb/tb_uart_tx_fifo.sv
// tb/tb_uart_tx_fifo.sv - randomized self-checking bench for uart_tx_fifo against a frame-position model
module tb_uart_tx_fifo;

  localparam int CPB   = 4;
  localparam int DB    = 8;
  localparam int SB    = 1;
  localparam int DEPTH = 16;
  localparam int LW    = 5;
`ifdef UART_TX_PARITY_EN
  localparam int PB = 1;
`else
  localparam int PB = 0;
`endif
  localparam int F = (1 + DB + PB + SB) * CPB;

  logic          clk = 1'b0;
  logic          reset = 1'b1;
  logic          wr_en = 1'b0;
  logic [DB-1:0] wr_data = '0;
  logic          full, empty, busy, overflow, uart_tx;
  logic [LW-1:0] level;

  uart_tx_fifo #(
    .CLKS_PER_BIT(CPB), .DATA_BITS(DB), .STOP_BITS(SB), .FIFO_DEPTH(DEPTH), .LVL_W(LW)
  ) dut (
    .clk(clk), .reset(reset), .wr_en(wr_en), .wr_data(wr_data), .full(full), .empty(empty),
    .level(level), .busy(busy), .overflow(overflow), .uart_tx(uart_tx)
  );

  always #5 clk = ~clk;

  int vectors = 0;
  int miscompares = 0;

  // Model: queue of accepted words plus position of the current cycle inside the frame (-1 = idle).
  logic [DB-1:0] mq[$];
  logic [DB-1:0] acc_q[$];
  logic [DB-1:0] cur = '0;
  int            pos = -1;
  logic          m_ovf = 1'b0;

  logic [DB-1:0] rx_q[$];
  logic [DB-1:0] rx_byte;
  int            rx_t = 0;
  bit            rx_active = 0;

  logic [9:0] got, expv;

  function automatic logic exp_tx();
    int b;
    if (pos < 0) return 1'b1;
    b = pos / CPB;
    if (b == 0) return 1'b0;
    if (b <= DB) return cur[b-1];
    if (PB == 1 && b == DB + 1) return ^cur;
    return 1'b1;
  endfunction

  function automatic logic [9:0] exp_vec();
    int n;
    n = mq.size();
    return {exp_tx(), n == DEPTH, n == 0, (pos >= 0) || (n > 0), m_ovf, LW'(n)};
  endfunction

  task automatic model_step();
    bit was_full, take;
    if (reset) begin
      mq.delete();
      pos   = -1;
      m_ovf = 1'b0;
    end else begin
      was_full = (mq.size() == DEPTH);
      take     = (mq.size() > 0) && (pos == -1 || pos == F - 1);
      m_ovf    = wr_en && was_full;
      if (take) begin
        cur = mq.pop_front();
        pos = 0;
      end else if (pos == -1 || pos == F - 1) begin
        pos = -1;
      end else begin
        pos++;
      end
      if (wr_en && !was_full) begin
        mq.push_back(wr_data);
        acc_q.push_back(wr_data);
      end
    end
  endtask

  task automatic rx_sample();
    if (reset) begin
      rx_active = 0;
    end else if (!rx_active) begin
      if (uart_tx === 1'b0) begin
        rx_active = 1;
        rx_t      = 0;
        rx_byte   = '0;
      end
    end else begin
      rx_t++;
      if (rx_t % CPB == CPB / 2 && rx_t / CPB >= 1 && rx_t / CPB <= DB)
        rx_byte[rx_t / CPB - 1] = uart_tx;
      if (rx_t == CPB * (1 + DB + PB) + CPB / 2) begin
        rx_q.push_back(rx_byte);
        rx_active = 0;
      end
    end
  endtask

  task automatic tick();
    @(posedge clk);
    model_step();
    #1;
    rx_sample();
  endtask

  task automatic test_reset();
    reset = 1'b1;
    wr_en = 1'b0;
    tick();
    tick();
    vectors += 6;
    if (uart_tx !== 1'b1) begin miscompares++; $display("FAIL reset_uart_tx got %b want 1", uart_tx); end
    if (full !== 1'b0) begin miscompares++; $display("FAIL reset_full got %b want 0", full); end
    if (empty !== 1'b1) begin miscompares++; $display("FAIL reset_empty got %b want 1", empty); end
    if (level !== '0) begin miscompares++; $display("FAIL reset_level got %0d want 0", level); end
    if (busy !== 1'b0) begin miscompares++; $display("FAIL reset_busy got %b want 0", busy); end
    if (overflow !== 1'b0) begin miscompares++; $display("FAIL reset_overflow got %b want 0", overflow); end
    reset = 1'b0;
    tick();
  endtask

  task automatic test_single();
    int first_low = -1;
    int busy_cnt = 0;
    int par_ones = 0;
    logic [DB-1:0] w;
`ifdef UART_TX_PARITY_EN
    w = 8'h07;
`else
    w = 8'hA5;
`endif
    rx_q.delete();
    wr_en = 1'b1; wr_data = w;
    tick();
    wr_en = 1'b0;
    if (busy === 1'b1) busy_cnt++;
    for (int i = 1; i <= F + 4; i++) begin
      tick();
      got = {uart_tx, full, empty, busy, overflow, level}; expv = exp_vec(); vectors++;
      if (got !== expv) begin miscompares++; $display("FAIL single cycle %0d got %b want %b", i, got, expv); end
      if (first_low < 0 && uart_tx === 1'b0) first_low = i;
      if (busy === 1'b1) busy_cnt++;
      if (i - 1 >= CPB * (1 + DB) && i - 1 < CPB * (1 + DB + PB) && uart_tx === 1'b1) par_ones++;
    end
    vectors += 3;
    if (first_low !== 1) begin miscompares++; $display("FAIL single_start_latency got %0d want 1", first_low); end
    if (busy_cnt !== F + 1) begin miscompares++; $display("FAIL single_busy_len got %0d want %0d", busy_cnt, F + 1); end
    if (rx_q.size() != 1 || rx_q[0] !== w) begin
      miscompares++; $display("FAIL single_rx got %0d words want 1 word %h", rx_q.size(), w);
    end
`ifdef UART_TX_PARITY_EN
    vectors++;
    if (par_ones !== CPB) begin miscompares++; $display("FAIL parity_bit high cycles got %0d want %0d", par_ones, CPB); end
`endif
  endtask

  task automatic test_burst();
    logic [DB-1:0] want [3];
    int i;
    want[0] = 8'h01; want[1] = 8'h02; want[2] = 8'h03;
    rx_q.delete();
    for (int k = 0; k < 3; k++) begin
      wr_en = 1'b1; wr_data = want[k];
      tick();
      got = {uart_tx, full, empty, busy, overflow, level}; expv = exp_vec(); vectors++;
      if (got !== expv) begin miscompares++; $display("FAIL burst push %0d got %b want %b", k, got, expv); end
    end
    wr_en = 1'b0;
    for (i = 0; i < 3 * F + 20 && !(pos == -1 && mq.size() == 0); i++) begin
      tick();
      got = {uart_tx, full, empty, busy, overflow, level}; expv = exp_vec(); vectors++;
      if (got !== expv) begin miscompares++; $display("FAIL burst cycle %0d got %b want %b", i, got, expv); end
    end
    vectors++;
    if (rx_q.size() != 3 || rx_q[0] !== want[0] || rx_q[1] !== want[1] || rx_q[2] !== want[2]) begin
      miscompares++; $display("FAIL burst_rx got %0d words want 3 (01 02 03)", rx_q.size());
    end
  endtask

  task automatic test_overflow();
    logic [DB-1:0] sent [18];
    int ovf_cnt = 0;
    bit ok;
    rx_q.delete();
    for (int k = 0; k < 18; k++) begin
      sent[k] = DB'($urandom);
      wr_en = 1'b1; wr_data = sent[k];
      tick();
      got = {uart_tx, full, empty, busy, overflow, level}; expv = exp_vec(); vectors++;
      if (got !== expv) begin miscompares++; $display("FAIL overflow push %0d got %b want %b", k, got, expv); end
      if (overflow === 1'b1) ovf_cnt++;
    end
    wr_en = 1'b0;
    for (int i = 0; i < 18 * F && !(pos == -1 && mq.size() == 0); i++) begin
      tick();
      got = {uart_tx, full, empty, busy, overflow, level}; expv = exp_vec(); vectors++;
      if (got !== expv) begin miscompares++; $display("FAIL overflow drain %0d got %b want %b", i, got, expv); end
      if (overflow === 1'b1) ovf_cnt++;
    end
    vectors += 2;
    if (ovf_cnt !== 1) begin miscompares++; $display("FAIL overflow_pulses got %0d want 1", ovf_cnt); end
    ok = (rx_q.size() == 17);
    for (int k = 0; k < 17 && ok; k++) if (rx_q[k] !== sent[k]) ok = 0;
    if (!ok) begin miscompares++; $display("FAIL overflow_rx got %0d words want first 17 pushed", rx_q.size()); end
  endtask

  task automatic test_wrap();
    logic [DB-1:0] sent[$];
    logic [DB-1:0] w;
    bit ok;
    rx_q.delete();
    for (int k = 0; k < 40; k++) begin
      w = DB'($urandom);
      sent.push_back(w);
      wr_en = 1'b1; wr_data = w;
      for (int g = 0; g < ((k < 8) ? 1 : F); g++) begin
        tick();
        wr_en = 1'b0;
        got = {uart_tx, full, empty, busy, overflow, level}; expv = exp_vec(); vectors++;
        if (got !== expv) begin miscompares++; $display("FAIL wrap word %0d cycle %0d got %b want %b", k, g, got, expv); end
      end
    end
    for (int i = 0; i < 18 * F && !(pos == -1 && mq.size() == 0); i++) begin
      tick();
      got = {uart_tx, full, empty, busy, overflow, level}; expv = exp_vec(); vectors++;
      if (got !== expv) begin miscompares++; $display("FAIL wrap drain %0d got %b want %b", i, got, expv); end
    end
    vectors++;
    ok = (rx_q.size() == sent.size());
    for (int k = 0; k < sent.size() && ok; k++) if (rx_q[k] !== sent[k]) ok = 0;
    if (!ok) begin miscompares++; $display("FAIL wrap_rx got %0d words want %0d in order", rx_q.size(), sent.size()); end
  endtask

  task automatic test_reset_mid();
    int i;
    for (int k = 0; k < 5; k++) begin
      wr_en = 1'b1; wr_data = (k == 0) ? 8'h5A : DB'($urandom);
      tick();
    end
    wr_en = 1'b0;
    for (i = 0; i < 50 && pos != CPB * 3 + 1; i++) tick();
    vectors += 2;
    if (pos != CPB * 3 + 1) begin miscompares++; $display("FAIL reset_mid_reach got pos %0d want %0d", pos, CPB * 3 + 1); end
    if (level !== LW'(4)) begin miscompares++; $display("FAIL reset_mid_queued got %0d want 4", level); end
    reset = 1'b1;
    tick();
    vectors += 4;
    if (uart_tx !== 1'b1) begin miscompares++; $display("FAIL reset_mid_tx got %b want 1", uart_tx); end
    if (level !== '0) begin miscompares++; $display("FAIL reset_mid_level got %0d want 0", level); end
    if (empty !== 1'b1) begin miscompares++; $display("FAIL reset_mid_empty got %b want 1", empty); end
    if (busy !== 1'b0) begin miscompares++; $display("FAIL reset_mid_busy got %b want 0", busy); end
    reset = 1'b0;
    rx_q.delete();
    wr_en = 1'b1; wr_data = 8'h3C;
    tick();
    wr_en = 1'b0;
    for (i = 0; i < 2 * F && !(pos == -1 && mq.size() == 0); i++) begin
      tick();
      got = {uart_tx, full, empty, busy, overflow, level}; expv = exp_vec(); vectors++;
      if (got !== expv) begin miscompares++; $display("FAIL reset_mid_after cycle %0d got %b want %b", i, got, expv); end
    end
    vectors++;
    if (rx_q.size() != 1 || rx_q[0] !== 8'h3C) begin
      miscompares++; $display("FAIL reset_mid_rx got %0d words want 1 word 3c", rx_q.size());
    end
  endtask

  task automatic test_random();
    bit ok;
    rx_q.delete();
    acc_q.delete();
    for (int i = 0; i < 600; i++) begin
      wr_en = ($urandom_range(0, 9) == 0);
      wr_data = DB'($urandom);
      tick();
      got = {uart_tx, full, empty, busy, overflow, level}; expv = exp_vec(); vectors++;
      if (got !== expv) begin miscompares++; $display("FAIL random cycle %0d got %b want %b", i, got, expv); end
    end
    wr_en = 1'b0;
    for (int i = 0; i < 18 * F && !(pos == -1 && mq.size() == 0); i++) begin
      tick();
      got = {uart_tx, full, empty, busy, overflow, level}; expv = exp_vec(); vectors++;
      if (got !== expv) begin miscompares++; $display("FAIL random drain %0d got %b want %b", i, got, expv); end
    end
    vectors++;
    ok = (rx_q.size() == acc_q.size()) && (pos == -1);
    for (int k = 0; k < acc_q.size() && ok; k++) if (rx_q[k] !== acc_q[k]) ok = 0;
    if (!ok) begin miscompares++; $display("FAIL random_rx got %0d words want %0d", rx_q.size(), acc_q.size()); end
  endtask

  initial begin
    test_reset();
    test_single();
    test_burst();
    test_overflow();
    test_wrap();
    test_reset_mid();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog expired at %0t", $time);
    $fatal(1, "watchdog");
  end

endmodule
